// File: rtl/apb3_cmd_master_pkg.sv
// rtl/apb3_cmd_master_pkg.sv - shared types and default widths for the APB3 command master
package apb3_cmd_master_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb3_cmd_master_if.sv
// rtl/apb3_cmd_master_if.sv - command/response stream plus APB3 bus bundle
interface apb3_cmd_master_if
  import apb3_cmd_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb3_cmd_master_wait_timer.sv
// rtl/apb3_cmd_master_wait_timer.sv - consecutive wait-state counter with expiry flag
module apb3_cmd_master_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Expiry fires during the TIMEOUT-th waiting cycle, so compare against TIMEOUT-1.
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (TIMEOUT > 0) && count && (cnt_q == LAST);

endmodule

// File: rtl/apb3_cmd_master.sv
// rtl/apb3_cmd_master.sv - APB3 requester turning a valid/ready command stream into single transfers
module apb3_cmd_master
  import apb3_cmd_master_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 64
) (
  input logic                pclk,
  input logic                presetn,
  apb3_cmd_master_if.master  bus
);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              tmo_expire;

  apb3_cmd_master_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk    (pclk),
    .rst_n  (presetn),
    .clear  (state_q == SETUP),
    .count  ((state_q == ACCESS) && !bus.pready),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // pready is checked first so a completion on the limit cycle is not a timeout.
        if (bus.pready || tmo_expire) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.pready ? bus.pslverr : 1'b1;
          rsp_timeout_d = !bus.pready;
          rsp_rdata_d   = (bus.pready && !pwrite_q && !bus.pslverr) ? bus.prdata : '0;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Gated by presetn so no command can appear accepted while reset is held.
  assign bus.cmd_ready   = (state_q == IDLE) && presetn;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb3_cmd_master.sv
// tb/tb_apb3_cmd_master.sv - directed self-checking bench for apb3_cmd_master
module tb_apb3_cmd_master;

  logic pclk;
  logic presetn;
  int   vectors;
  int   errors;

  apb3_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb3_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic start_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    presetn = 1'b1;
    #3 presetn = 1'b0;
    tick();
    tick();
    vectors++;
    if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready, bus.rsp_err, bus.rsp_timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready, bus.rsp_err, bus.rsp_timeout});
    end
    vectors++;
    if ({bus.paddr, bus.pwdata, bus.rsp_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {bus.paddr, bus.pwdata, bus.rsp_rdata});
    end
    presetn = 1'b1;
    #1;
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", bus.cmd_ready);
    end
  endtask

  task automatic test_write();
    start_cmd(1'b1, 32'h4, 32'h64);
    vectors++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.cmd_ready} !== 4'b1010 || bus.paddr !== 32'h4 || bus.pwdata !== 32'h64) begin
      errors++;
      $display("FAIL write_setup: got ctl=%b addr=%h data=%h expected 1010/4/64",
               {bus.psel, bus.penable, bus.pwrite, bus.cmd_ready}, bus.paddr, bus.pwdata);
    end
    tick();
    vectors++;
    if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) begin
      errors++;
      $display("FAIL write_access: got %b expected 110", {bus.psel, bus.penable, bus.rsp_valid});
    end
    tick();
    vectors++;
    if ({bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 5'b00100 || bus.rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL write_resp: got %b rdata=%h expected 00100/0",
               {bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, bus.rsp_rdata);
    end
    tick();
    vectors++;
    if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01 || bus.paddr !== 32'h4) begin
      errors++;
      $display("FAIL write_idle: got %b addr=%h expected 01/4", {bus.rsp_valid, bus.cmd_ready}, bus.paddr);
    end
  endtask

  task automatic test_wait_read();
    bus.pready = 1'b0;
    start_cmd(1'b0, 32'h8, 32'hFFFF);
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) begin
        errors++;
        $display("FAIL wait_penable_%0d: got %b expected 110", i, {bus.psel, bus.penable, bus.rsp_valid});
      end
      if (i == 3) begin
        bus.pready = 1'b1;
        bus.prdata = 32'h32;
      end
    end
    tick();
    vectors++;
    if ({bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 4'b0100 || bus.rsp_rdata !== 32'h32) begin
      errors++;
      $display("FAIL wait_read_resp: got %b rdata=%h expected 0100/32",
               {bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, bus.rsp_rdata);
    end
    bus.prdata = 32'h0;
    tick();
  endtask

  task automatic test_slverr();
    bus.pslverr = 1'b1;
    bus.prdata  = 32'hDEAD;
    start_cmd(1'b0, 32'h10, 32'h0);
    tick();
    tick();
    vectors++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 3'b110 || bus.rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL slverr_resp: got %b rdata=%h expected 110/0",
               {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, bus.rsp_rdata);
    end
    bus.pslverr = 1'b0;
    bus.prdata  = 32'h0;
    tick();
  endtask

  task automatic test_timeout(input logic late_ready);
    bus.pready = 1'b0;
    start_cmd(1'b0, 32'hC, 32'h0);
    for (int i = 0; i < 16; i++) begin
      tick();
      vectors++;
      if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) begin
        errors++;
        $display("FAIL timeout_access_%0d: got %b expected 110", i, {bus.psel, bus.penable, bus.rsp_valid});
      end
      if (late_ready && i == 15) begin
        bus.pready = 1'b1;
        bus.prdata = 32'h55;
      end
    end
    tick();
    vectors++;
    if (late_ready) begin
      if ({bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 4'b0100 || bus.rsp_rdata !== 32'h55) begin
        errors++;
        $display("FAIL timeout_edge_ready: got %b rdata=%h expected 0100/55",
                 {bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, bus.rsp_rdata);
      end
    end else begin
      if ({bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 5'b00111 || bus.rsp_rdata !== 32'h0) begin
        errors++;
        $display("FAIL timeout_resp: got %b rdata=%h expected 00111/0",
                 {bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, bus.rsp_rdata);
      end
    end
    bus.pready = 1'b1;
    bus.prdata = 32'h0;
    tick();
  endtask

  task automatic test_rsp_stall();
    bus.rsp_ready = 1'b0;
    start_cmd(1'b1, 32'h14, 32'hA5);
    tick();
    tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h99;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({bus.rsp_valid, bus.rsp_err, bus.cmd_ready, bus.psel} !== 4'b1000 || bus.paddr !== 32'h14) begin
        errors++;
        $display("FAIL stall_hold_%0d: got %b addr=%h expected 1000/14",
                 i, {bus.rsp_valid, bus.rsp_err, bus.cmd_ready, bus.psel}, bus.paddr);
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    vectors++;
    if ({bus.rsp_valid, bus.cmd_ready, bus.psel} !== 3'b010) begin
      errors++;
      $display("FAIL stall_release: got %b expected 010", {bus.rsp_valid, bus.cmd_ready, bus.psel});
    end
  endtask

  task automatic test_back_to_back();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h20;
    bus.cmd_wdata = 32'h1;
    tick();
    bus.cmd_addr  = 32'h24;
    bus.cmd_wdata = 32'h2;
    tick();
    tick();
    tick();
    vectors++;
    if ({bus.psel, bus.cmd_ready} !== 2'b01 || bus.paddr !== 32'h20 || bus.pwdata !== 32'h1) begin
      errors++;
      $display("FAIL b2b_gap: got %b addr=%h data=%h expected 01/20/1",
               {bus.psel, bus.cmd_ready}, bus.paddr, bus.pwdata);
    end
    tick();
    bus.cmd_valid = 1'b0;
    vectors++;
    if ({bus.psel, bus.penable} !== 2'b10 || bus.paddr !== 32'h24 || bus.pwdata !== 32'h2) begin
      errors++;
      $display("FAIL b2b_second: got %b addr=%h data=%h expected 10/24/2",
               {bus.psel, bus.penable}, bus.paddr, bus.pwdata);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    bus.pready = 1'b0;
    start_cmd(1'b0, 32'h30, 32'h0);
    tick();
    presetn = 1'b0;
    #1;
    vectors++;
    if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== 4'b0000 || bus.paddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got %b addr=%h expected 0000/0",
               {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}, bus.paddr);
    end
    bus.pready = 1'b1;
    tick();
    presetn = 1'b1;
    #1;
    tick();
    vectors++;
    if ({bus.psel, bus.rsp_valid, bus.cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_mid_idle: got %b expected 001", {bus.psel, bus.rsp_valid, bus.cmd_ready});
    end
  endtask

  initial begin
    vectors       = 0;
    errors        = 0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b1;
    bus.prdata    = 32'h0;
    bus.pready    = 1'b1;
    bus.pslverr   = 1'b0;
    test_reset();
    test_write();
    test_wait_read();
    test_slverr();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_rsp_stall();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
